dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single-port data memory between the pipeline MEM stage (CPU port)
//  and a secondary bus master (DMA/peripheral loader port).
//  The CPU port has priority. A starvation counter forces a one-cycle DMA slot
//  and stalls the pipeline. Sits between the MEM stage and DataMem.
// PARAMETERS
//  ADDR_W      32  address width, both ports
//  DATA_W      32  data width, both ports
//  STARVE_MAX  4   consecutive blocked DMA cycles before a forced DMA slot (>=1)
// PORTS
//  clk        in   1       system clock, rising edge
//  reset_b    in   1       asynchronous reset, active low
//  cpu_rd     in   1       MEM stage read request
//  cpu_wr     in   1       MEM stage write request
//  cpu_addr   in   ADDR_W  MEM stage address (ALU result)
//  cpu_wdata  in   DATA_W  MEM stage write data
//  cpu_rdata  out  DATA_W  read data to MEM stage, combinational
//  cpu_stall  out  1       CPU access not performed this cycle; pipeline must hold
//  dma_req    in   1       DMA access request, held until dma_gnt
//  dma_we     in   1       1 = write, 0 = read; valid with dma_req
//  dma_addr   in   ADDR_W  DMA address
//  dma_wdata  in   DATA_W  DMA write data
//  dma_gnt    out  1       DMA access performed this cycle
//  dma_rvalid out  1       registered DMA read data valid, 1 cycle
//  dma_rdata  out  DATA_W  registered DMA read data
//  mem_rd     out  1       to DataMem rd
//  mem_wr     out  1       to DataMem wr
//  mem_addr   out  ADDR_W  to DataMem addr
//  mem_wdata  out  DATA_W  to DataMem wdata
//  mem_rdata  in   DATA_W  from DataMem rdata, combinational
// BEHAVIOUR
//  - cpu_act = cpu_rd|cpu_wr.
//    dma_sel = dma_req & (~cpu_act | starve_cnt==STARVE_MAX).
//  - dma_gnt = dma_sel. cpu_stall = cpu_act & dma_sel.
//  - Mux: if dma_sel, mem_addr/wdata come from the DMA port,
//    with mem_rd=~dma_we and mem_wr=dma_we.
//    Otherwise they come from the CPU port with mem_rd=cpu_rd and mem_wr=cpu_wr.
//    Idle: mem_rd=mem_wr=0, and addr/wdata follow the CPU port.
//  - cpu_rdata = mem_rdata, always; the value is meaningful only when cpu_stall=0.
//  - Write commits on the clk edge ending the granted cycle, per DataMem.
//  - starve_cnt, width clog2(STARVE_MAX+1). At posedge, in priority order:
//    1. dma_sel: cleared to 0.
//    2. dma_req & cpu_act: +1, saturating at STARVE_MAX.
//    3. ~dma_req: cleared to 0.
//  - Clearing after a forced slot guarantees the CPU at least STARVE_MAX cycles
//    between forced slots. DMA never starves longer than STARVE_MAX cycles.
//  - Read return: on a granted DMA read, dma_rdata<=mem_rdata at that posedge.
//    dma_rvalid=1 for the next cycle only.
//    Back-to-back DMA reads give back-to-back rvalid.
//    dma_rdata holds its last value otherwise.
//  - Simultaneous: cpu_rd and cpu_wr both high is illegal (assertion).
//    DMA request with no CPU activity is granted the same cycle (0 wait).
//  - Reset (reset_b low, any time): starve_cnt=0, dma_rvalid=0, dma_rdata=0.
//    Combinational outputs are forced: mem_rd=mem_wr=0, dma_gnt=0, cpu_stall=0.
//    A DMA read granted in the cycle reset asserts yields no rvalid; it must re-request.
// TESTING
//  1. Reset, then CPU wr 0x10<=0xCAFEF00D, then CPU rd 0x10.
//     -> cpu_rdata=0xCAFEF00D, cpu_stall=0 throughout.
//  2. CPU idle, DMA rd 0x20 (holding 0x1234).
//     -> dma_gnt same cycle, dma_rvalid next cycle, dma_rdata=0x1234.
//  3. CPU rd every cycle, dma_req held, STARVE_MAX=4.
//     -> dma_gnt and cpu_stall on the 5th cycle only; CPU served again the next cycle.
//  4. Same as 3 with dma_req held for 12 cycles.
//     -> grants at cycles 5 and 10; the CPU is never stalled 2 cycles in a row.
//  5. DMA wr 0x30<=0xA5A5A5A5 with CPU rd 0x30 in the same forced cycle, CPU retries.
//     -> CPU sees 0xA5A5A5A5 after the stall.
//  6. Assert reset_b low during a granted DMA read.
//     -> dma_rvalid stays 0, starve_cnt=0, mem_wr=0 while in reset.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter
//   Shares the single-port data memory between the pipeline MEM stage (CPU
//   port) and a secondary bus master (DMA / peripheral loader port). The CPU
//   normally wins. A DMA request that has been blocked for STARVE_MAX
//   consecutive cycles gets a forced one-cycle slot, during which the CPU
//   access is not performed and the pipeline is stalled.
//
// Ports
//   clk, reset_b                  clock (rising edge), async active-low reset
//   cpu_rd/cpu_wr/cpu_addr/
//   cpu_wdata                     MEM stage request
//   cpu_rdata                     read data to MEM stage (combinational)
//   cpu_stall                     CPU access not performed this cycle
//   dma_req/dma_we/dma_addr/
//   dma_wdata                     DMA request, held until dma_gnt
//   dma_gnt                       DMA access performed this cycle
//   dma_rvalid/dma_rdata          registered DMA read return, one cycle later
//   mem_rd/mem_wr/mem_addr/
//   mem_wdata/mem_rdata           DataMem side
// ---------------------------------------------------------------------------
module dmem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  // Blocked-cycle count, holding at CNT_MAX until the forced slot clears it.
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  logic             cpuAct;
  logic             starveHit;
  logic             dmaSel;
  logic             dmaRdGrant;
  logic [CNT_W-1:0] starveCnt;

  assign cpuAct     = cpu_rd | cpu_wr;
  assign starveHit  = (starveCnt == CNT_MAX);
  // reset_b gates the grant so nothing reaches DataMem while in reset,
  // and a read granted in the reset cycle never produces an rvalid.
  assign dmaSel     = reset_b & dma_req & (~cpuAct | starveHit);
  assign dmaRdGrant = dmaSel & ~dma_we;

  assign dma_gnt   = dmaSel;
  assign cpu_stall = cpuAct & dmaSel;
  assign cpu_rdata = mem_rdata;

  // ---- stage 0: port mux into DataMem (combinational) ----
  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    if (dmaSel) begin
      mem_rd    = ~dma_we;
      mem_wr    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end else if (reset_b) begin
      mem_rd = cpu_rd;
      mem_wr = cpu_wr;
    end
  end

  // ---- stage 1: starvation counter and registered DMA read return ----
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      starveCnt  <= '0;
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
    end else begin
      if (dmaSel) begin
        starveCnt <= '0;
      end else if (dma_req && cpuAct) begin
        starveCnt <= satInc(starveCnt);
      end else if (!dma_req) begin
        starveCnt <= '0;
      end
      dma_rvalid <= dmaRdGrant;
      if (dmaRdGrant) begin
        dma_rdata <= mem_rdata;
      end
    end
  end

  // The MEM stage issues at most one of read/write per cycle.
  cpuRdWrExclusive: assert property (@(posedge clk) disable iff (!reset_b)
    !(cpu_rd && cpu_wr));

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_port_arbiter
//   Self-checking bench for dmem_port_arbiter. Provides a DataMem model
//   (combinational read, write at posedge), a cycle-level reference model of
//   the arbitration rules, table-driven single-cycle vectors, directed
//   multi-cycle sequences and a randomized run.
// ---------------------------------------------------------------------------
module tb_dmem_port_arbiter;

  localparam int SM = 4;

  logic        clk = 1'b0;
  logic        reset_b;
  logic        cpu_rd, cpu_wr;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dma_req, dma_we;
  logic [31:0] dma_addr, dma_wdata;
  logic        dma_gnt, dma_rvalid;
  logic [31:0] dma_rdata;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset_b(reset_b),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // DataMem: 256 words, address taken modulo 256.
  logic [31:0] mem [0:255] = '{default: '0};
  assign mem_rdata = mem[8'(mem_addr)];
  always @(posedge clk) if (mem_wr) mem[8'(mem_addr)] <= mem_wdata;

  // Reference model state
  logic [31:0] refMem [0:255] = '{default: '0};
  int          blocked;      // consecutive cycles the current DMA request was refused
  logic        expRvalid;
  logic [31:0] expRdata;

  // Values observed in the most recent step
  logic        sGnt, sStall, sRd, sWr, sRvalid;
  logic [31:0] sAddr, sCpuRdata, sRdata;

  int nChecks = 0;
  int nFail   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // One clock cycle: entered at posedge+1, leaves at next posedge+1.
  task automatic step(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                      input logic dr, input logic dwe, input logic [31:0] da, input logic [31:0] dd);
    logic act, eGnt, eStall, eRd, eWr;
    logic [31:0] eAddr, eWd;
    cpu_rd = cr; cpu_wr = cw; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dr; dma_we = dwe; dma_addr = da; dma_wdata = dd;
    act    = cr | cw;
    eGnt   = dr && (!act || blocked >= SM);
    eStall = act && eGnt;
    if (eGnt) begin eRd = !dwe; eWr = dwe; eAddr = da; eWd = dd; end
    else      begin eRd = cr;   eWr = cw;  eAddr = ca; eWd = cd; end
    @(negedge clk);
    sGnt = dma_gnt; sStall = cpu_stall; sRd = mem_rd; sWr = mem_wr;
    sAddr = mem_addr; sCpuRdata = cpu_rdata;
    chk("dma_gnt", dma_gnt, eGnt);
    chk("cpu_stall", cpu_stall, eStall);
    chk("mem_rd", mem_rd, eRd);
    chk("mem_wr", mem_wr, eWr);
    chk("mem_addr", mem_addr, eAddr);
    if (eWr) chk("mem_wdata", mem_wdata, eWd);
    if (cr && !eStall) chk("cpu_rdata", cpu_rdata, refMem[ca[7:0]]);
    // model update
    expRvalid = eGnt && !dwe;
    if (expRvalid) expRdata = refMem[da[7:0]];
    if (eGnt && dwe) refMem[da[7:0]] = dd;
    else if (cw && !eStall) refMem[ca[7:0]] = cd;
    if (eGnt) blocked = 0;
    else if (dr) blocked = (blocked + 1 > SM) ? SM : blocked + 1;
    else blocked = 0;
    @(posedge clk); #1;
    sRvalid = dma_rvalid; sRdata = dma_rdata;
    chk("dma_rvalid", dma_rvalid, expRvalid);
    chk("dma_rdata", dma_rdata, expRdata);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  typedef struct {
    logic cr, cw, dr, dwe;
    logic eGnt, eStall, eRd, eWr, fromDma;
  } vec_t;

  initial begin
    vec_t vecs [8];
    logic pend, pwe, prevStall, got;
    logic [31:0] pa, pd;
    int waitCnt;

    vecs[0] = '{0,0,0,0, 0,0,0,0,0};
    vecs[1] = '{1,0,0,0, 0,0,1,0,0};
    vecs[2] = '{0,1,0,0, 0,0,0,1,0};
    vecs[3] = '{0,0,1,0, 1,0,1,0,1};
    vecs[4] = '{0,0,1,1, 1,0,0,1,1};
    vecs[5] = '{1,0,1,0, 0,0,1,0,0};
    vecs[6] = '{0,1,1,1, 0,0,0,1,0};
    vecs[7] = '{1,0,1,1, 0,0,1,0,0};

    // Reset state, with requests present on both ports
    reset_b = 1'b0;
    cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h8; cpu_wdata = 32'h0;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h9; dma_wdata = 32'h0;
    blocked = 0; expRvalid = 1'b0; expRdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", dma_gnt, 1'b0);
    chk("rst_stall", cpu_stall, 1'b0);
    chk("rst_mem_rd", mem_rd, 1'b0);
    chk("rst_mem_wr", mem_wr, 1'b0);
    chk("rst_rvalid", dma_rvalid, 1'b0);
    chk("rst_rdata", dma_rdata, 32'h0);
    cpu_rd = 1'b0; dma_req = 1'b0;
    @(posedge clk); #1;
    reset_b = 1'b1;

    // 1: CPU write then read
    step(1'b0, 1'b1, 32'h10, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("t1_wr_stall", sStall, 1'b0);
    step(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("t1_rdata", sCpuRdata, 32'hCAFEF00D);
    chk("t1_rd_stall", sStall, 1'b0);

    // 2: DMA read with CPU idle
    step(1'b0, 1'b1, 32'h20, 32'h1234, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
    chk("t2_gnt", sGnt, 1'b1);
    chk("t2_rvalid", sRvalid, 1'b1);
    chk("t2_rdata", sRdata, 32'h1234);
    idle();
    chk("t2_rvalid_drop", sRvalid, 1'b0);
    chk("t2_rdata_hold", sRdata, 32'h1234);

    // Table-driven single-cycle vectors, each from a cleared counter
    for (int i = 0; i < 8; i++) begin
      logic [31:0] ca, da;
      idle();
      ca = 32'h50 + 32'(i);
      da = 32'h60 + 32'(i);
      step(vecs[i].cr, vecs[i].cw, ca, $urandom, vecs[i].dr, vecs[i].dwe, da, $urandom);
      chk("tbl_gnt", sGnt, vecs[i].eGnt);
      chk("tbl_stall", sStall, vecs[i].eStall);
      chk("tbl_mem_rd", sRd, vecs[i].eRd);
      chk("tbl_mem_wr", sWr, vecs[i].eWr);
      chk("tbl_mem_addr", sAddr, vecs[i].fromDma ? da : ca);
    end
    idle();

    // 3: CPU reads every cycle, DMA holds its request until granted
    got = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0, 32'h10, 32'h0, !got, 1'b0, 32'h20, 32'h0);
      if (sGnt) got = 1'b1;
      chk("t3_gnt", sGnt, i == 5);
      chk("t3_stall", sStall, i == 5);
    end

    // 4: DMA request held for 12 cycles against continuous CPU reads
    prevStall = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
      chk("t4_gnt", sGnt, (i == 5) || (i == 10));
      chk("t4_no_double_stall", prevStall & sStall, 1'b0);
      prevStall = sStall;
    end
    idle();

    // 5: forced DMA write collides with CPU read of the same word
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step(1'b1, 1'b0, 32'h30, 32'h0, 1'b1, 1'b1, 32'h30, 32'hA5A5A5A5);
      if (sGnt) begin
        got = 1'b1;
        chk("t5_stall_at_grant", sStall, 1'b1);
      end
    end
    chk("t5_grant_seen", got, 1'b1);
    step(1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("t5_retry_stall", sStall, 1'b0);
    chk("t5_retry_rdata", sCpuRdata, 32'hA5A5A5A5);

    // 6: reset asserted during a forced, granted DMA read
    for (int i = 0; i < SM; i++)
      step(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
    cpu_rd = 1'b1; cpu_addr = 32'h40; dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h20;
    #2;
    chk("t6_pre_gnt", dma_gnt, 1'b1);
    #1 reset_b = 1'b0;
    #1;
    chk("t6_rst_gnt", dma_gnt, 1'b0);
    chk("t6_rst_stall", cpu_stall, 1'b0);
    chk("t6_rst_mem_rd", mem_rd, 1'b0);
    dma_we = 1'b1;
    #1;
    chk("t6_rst_mem_wr", mem_wr, 1'b0);
    @(posedge clk); #1;
    chk("t6_rst_rvalid", dma_rvalid, 1'b0);
    chk("t6_rst_rdata", dma_rdata, 32'h0);
    @(negedge clk);
    chk("t6_rst_mem_wr2", mem_wr, 1'b0);
    @(posedge clk); #1;
    reset_b = 1'b1;
    blocked = 0; expRvalid = 1'b0; expRdata = '0;
    // Cleared counter: the re-requested read waits the full starvation window
    got = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, 1'b0, 32'h40, 32'h0, !got, 1'b0, 32'h20, 32'h0);
      if (sGnt) got = 1'b1;
      chk("t6_post_gnt", sGnt, i == 5);
    end

    // Randomized traffic against the reference model
    pend = 1'b0; pwe = 1'b0; pa = '0; pd = '0; waitCnt = 0; prevStall = 1'b0;
    for (int i = 0; i < 400; i++) begin
      int op;
      op = $urandom_range(0, 3);
      if (!pend && $urandom_range(0, 1) == 1) begin
        pend = 1'b1; pwe = 1'($urandom_range(0, 1));
        pa = 32'($urandom_range(0, 15)); pd = $urandom; waitCnt = 0;
      end
      step(op == 1 || op == 3, op == 2, 32'($urandom_range(0, 15)), $urandom,
           pend, pwe, pa, pd);
      if (pend) begin
        waitCnt++;
        if (sGnt) begin
          chk("rnd_max_wait", waitCnt <= SM + 1, 1'b1);
          pend = 1'b0;
        end
      end
      chk("rnd_no_double_stall", prevStall & sStall, 1'b0);
      prevStall = sStall;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
